// File: rtl/ddp_mm_pkg.sv
// Shared constants and types for the matching-memory entry array.
package ddp_mm_pkg;

    localparam int unsigned N_ENTRY = 20;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned KEY_W   = 16;
    localparam int unsigned DATA_W  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMatch = 2'd1,
        StAct   = 2'd2,
        StOut   = 2'd3
    } mm_state_e;

    typedef struct packed {
        logic              valid;
        logic              lr;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
    } mm_entry_t;

endpackage

// File: rtl/mm_entry.sv
// One matching-memory entry: valid/lr/key/data registers, write port,
// synchronous clear, and the key comparator that produces its FIRE bit.
module mm_entry #(
    parameter int unsigned KEY_W  = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic              clr_i,
    input  logic              lr_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              cmp_en_i,
    input  logic [KEY_W-1:0]  cmp_key_i,
    output logic              valid_o,
    output logic              lr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              fire_o
);

    logic              valid_q, valid_d;
    logic              lr_q, lr_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state: a write wins over a clear; both never arrive together.
    always_comb begin
        valid_d = valid_q;
        lr_d    = lr_q;
        key_d   = key_q;
        data_d  = data_q;
        if (wr_i) begin
            valid_d = 1'b1;
            lr_d    = lr_i;
            key_d   = key_i;
            data_d  = data_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            lr_q    <= 1'b0;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            lr_q    <= lr_d;
            key_q   <= key_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign lr_o    = lr_q;
    assign data_o  = data_q;
    assign fire_o  = valid_q & cmp_en_i & (key_q == cmp_key_i);

endmodule

// File: rtl/mm_entry_array.sv
// Matching-memory entry array: holds one incoming packet, searches all
// entries for its key, then executes the controller's store/delete command
// and presents matched pairs or bypassed packets on the output port.
// Optional occupancy counter output OCC is enabled by defining DDP_MM_OCC_EN.
module mm_entry_array #(
    parameter int unsigned N_ENTRY = ddp_mm_pkg::N_ENTRY,
    parameter int unsigned KEY_W   = ddp_mm_pkg::KEY_W,
    parameter int unsigned DATA_W  = ddp_mm_pkg::DATA_W
) (
    input  logic                          CP,
    input  logic                          MR,
    input  logic                          IN_REQ,
    output logic                          IN_ACK,
    input  logic                          IN_MF,
    input  logic                          IN_LR,
    input  logic [KEY_W-1:0]              IN_KEY,
    input  logic [DATA_W-1:0]             IN_DATA,
    output logic [N_ENTRY-1:0]            FIRE,
    output logic [N_ENTRY-1:0]            VALID,
    output logic                          MF,
    input  logic [N_ENTRY-1:0]            EN,
    input  logic                          WR_E,
    input  logic                          DEL,
    input  logic [ddp_mm_pkg::ADDR_W-1:0] ADDR,
    output logic                          OUT_REQ,
    input  logic                          OUT_ACK,
    output logic                          OUT_PAIR,
    output logic [KEY_W-1:0]              OUT_KEY,
    output logic [DATA_W-1:0]             OUT_L,
    output logic [DATA_W-1:0]             OUT_R,
`ifdef DDP_MM_OCC_EN
    output logic                          OVF,
    output logic [ddp_mm_pkg::ADDR_W-1:0] OCC
`else
    output logic                          OVF
`endif
);

    import ddp_mm_pkg::*;

    mm_state_e         state_q, state_d;
    logic              mf_q, mf_d;
    logic              lr_q, lr_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              en_any_q, en_any_d;
    logic              ovf_q, ovf_d;
    logic              out_pair_q, out_pair_d;
    logic [KEY_W-1:0]  out_key_q, out_key_d;
    logic [DATA_W-1:0] out_l_q, out_l_d;
    logic [DATA_W-1:0] out_r_q, out_r_d;

    logic [N_ENTRY-1:0] ent_valid, ent_lr, ent_fire, ent_wr, ent_clr, addr_dec;
    logic [DATA_W-1:0]  ent_data [N_ENTRY];
    logic [DATA_W-1:0]  rd_data;
    logic               act, addr_ok, do_del, do_wr, cmp_en;

    // Stored side is kept per entry for debug visibility only.
    logic unused_lr;
    assign unused_lr = ^ent_lr;

    // Decode ADDR; out-of-range addresses decode to no entry at all.
    always_comb begin
        addr_dec = '0;
        for (int i = 0; i < int'(N_ENTRY); i++) begin
            addr_dec[i] = (ADDR == ADDR_W'(i));
        end
    end

    assign act     = (state_q == StAct);
    assign addr_ok = |addr_dec;
    assign do_del  = act & mf_q & DEL;
    assign do_wr   = act & mf_q & ~DEL & WR_E & en_any_q;
    assign ent_clr = {N_ENTRY{do_del}} & addr_dec;
    assign ent_wr  = {N_ENTRY{do_wr}} & addr_dec;
    assign cmp_en  = (state_q == StMatch) & mf_q;

    // Read mux for the partner entry selected by ADDR.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(N_ENTRY); i++) begin
            rd_data = rd_data | (ent_data[i] & {DATA_W{addr_dec[i]}});
        end
    end

    for (genvar g = 0; g < int'(N_ENTRY); g++) begin : g_entry
        mm_entry #(
            .KEY_W  (KEY_W),
            .DATA_W (DATA_W)
        ) u_entry (
            .clk_i     (CP),
            .rst_ni    (MR),
            .wr_i      (ent_wr[g]),
            .clr_i     (ent_clr[g]),
            .lr_i      (lr_q),
            .key_i     (key_q),
            .data_i    (data_q),
            .cmp_en_i  (cmp_en),
            .cmp_key_i (key_q),
            .valid_o   (ent_valid[g]),
            .lr_o      (ent_lr[g]),
            .data_o    (ent_data[g]),
            .fire_o    (ent_fire[g])
        );
    end

    // Packet FSM: capture, search, act on the controller command, present output.
    always_comb begin
        state_d    = state_q;
        mf_d       = mf_q;
        lr_d       = lr_q;
        key_d      = key_q;
        data_d     = data_q;
        en_any_d   = en_any_q;
        ovf_d      = ovf_q;
        out_pair_d = out_pair_q;
        out_key_d  = out_key_q;
        out_l_d    = out_l_q;
        out_r_d    = out_r_q;
        unique case (state_q)
            StIdle: begin
                if (IN_REQ) begin
                    mf_d    = IN_MF;
                    lr_d    = IN_LR;
                    key_d   = IN_KEY;
                    data_d  = IN_DATA;
                    state_d = StMatch;
                end
            end
            StMatch: begin
                en_any_d = |EN;
                state_d  = StAct;
            end
            StAct: begin
                state_d = StIdle;
                if (!mf_q) begin
                    out_pair_d = 1'b0;
                    out_key_d  = key_q;
                    out_l_d    = data_q;
                    out_r_d    = '0;
                    state_d    = StOut;
                end else if (DEL) begin
                    if (addr_ok) begin
                        out_pair_d = 1'b1;
                        out_key_d  = key_q;
                        out_l_d    = lr_q ? rd_data : data_q;
                        out_r_d    = lr_q ? data_q : rd_data;
                        state_d    = StOut;
                    end
                end else if (WR_E) begin
                    // Full array or bad address: the packet is lost.
                    if (!en_any_q || !addr_ok) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            StOut: begin
                if (OUT_ACK) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge CP) begin
        if (!MR) begin
            state_q    <= StIdle;
            mf_q       <= 1'b0;
            lr_q       <= 1'b0;
            key_q      <= '0;
            data_q     <= '0;
            en_any_q   <= 1'b0;
            ovf_q      <= 1'b0;
            out_pair_q <= 1'b0;
            out_key_q  <= '0;
            out_l_q    <= '0;
            out_r_q    <= '0;
        end else begin
            state_q    <= state_d;
            mf_q       <= mf_d;
            lr_q       <= lr_d;
            key_q      <= key_d;
            data_q     <= data_d;
            en_any_q   <= en_any_d;
            ovf_q      <= ovf_d;
            out_pair_q <= out_pair_d;
            out_key_q  <= out_key_d;
            out_l_q    <= out_l_d;
            out_r_q    <= out_r_d;
        end
    end

    assign IN_ACK   = (state_q == StIdle);
    assign OUT_REQ  = (state_q == StOut);
    assign FIRE     = ent_fire;
    assign VALID    = ent_valid;
    assign MF       = mf_q;
    assign OVF      = ovf_q;
    assign OUT_PAIR = out_pair_q;
    assign OUT_KEY  = out_key_q;
    assign OUT_L    = out_l_q;
    assign OUT_R    = out_r_q;

`ifdef DDP_MM_OCC_EN
    logic [ADDR_W-1:0] occ_q, occ_d;
    logic              occ_inc, occ_dec;

    // Count only real occupancy changes, in step with the VALID update.
    assign occ_inc = |(ent_wr & ~ent_valid);
    assign occ_dec = |(ent_clr & ent_valid);

    // Occupancy next-state.
    always_comb begin
        occ_d = occ_q;
        if (occ_inc) begin
            occ_d = occ_q + ADDR_W'(1);
        end else if (occ_dec) begin
            occ_d = occ_q - ADDR_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge CP) begin
        if (!MR) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign OCC = occ_q;
`endif

endmodule

// File: doc/mm_entry_array.md
# mm_entry_array

Matching-memory entry array for the data-driven processor: stores waiting operand packets in 20 entries, compares each incoming packet's key against all valid entries, and drives `FIRE`/`VALID`/`MF` to the matching-memory controller. It then executes the controller's registered `WR_E`/`DEL`/`ADDR` command: store the packet, or read out and free the partner entry. Matched pairs and non-matching (single-operand) packets leave through a request/acknowledge output port toward the firing/function stage.

## Interface
Parameters:
- `N_ENTRY`, default 20: entry count. Fixed to match the controller's 20-bit `FIRE`/`VALID`/`EN`.
- `KEY_W`, default 16: match key width (destination node plus colour).
- `DATA_W`, default 16: operand data width.

Ports:
- `CP`, in, 1: clock. The controller also runs on this clock.
- `MR`, in, 1: reset, synchronous, active-low.
- `IN_REQ`, in, 1: input packet valid.
- `IN_ACK`, out, 1: input ready; a transfer occurs on an edge where `IN_REQ & IN_ACK`.
- `IN_MF`, in, 1: packet requires matching.
- `IN_LR`, in, 1: operand side, 0 = left, 1 = right.
- `IN_KEY`, in, KEY_W: match key.
- `IN_DATA`, in, DATA_W: operand.
- `FIRE`, out, N_ENTRY: to controller; per-entry key hit.
- `VALID`, out, N_ENTRY: to controller; entry occupied.
- `MF`, out, 1: to controller; `MF` of the held packet.
- `EN`, in, N_ENTRY: from controller; one-hot free entry, all-zero if none.
- `WR_E`, in, 1: from controller; store command.
- `DEL`, in, 1: from controller; read and free command.
- `ADDR`, in, 6: from controller; target entry index.
- `OUT_REQ`, out, 1: output packet valid.
- `OUT_ACK`, in, 1: output accepted.
- `OUT_PAIR`, out, 1: 1 = matched pair, 0 = single-operand bypass.
- `OUT_KEY`, out, KEY_W: key of the output packet.
- `OUT_L`, out, DATA_W: left operand.
- `OUT_R`, out, DATA_W: right operand.
- `OVF`, out, 1: sticky overflow flag.

## Operation
- State machine states: IDLE, MATCH, ACT, OUT.
- IDLE: `IN_ACK`=1. On transfer, capture MF/LR/KEY/DATA into the hold register and go to MATCH.
- MATCH, one cycle:
  - `FIRE[i]` = `VALID[i]` & (`key[i]` == held key) & held MF.
  - `MF` = held MF.
  - The array registers `|EN` into `en_any`.
  - Go to ACT.
- ACT, one cycle; controller outputs are valid now.
  - Held MF=0: ignore `WR_E`/`DEL`/`ADDR`. Load OUT_L = data, OUT_R = 0, OUT_PAIR = 0. Go to OUT.
  - `DEL`=1: read entry[`ADDR`] and clear `VALID[ADDR]`.
    - Held LR=0: OUT_L = held data, OUT_R = entry data.
    - Held LR=1: reversed.
    - Set OUT_PAIR = 1, OUT_KEY = held key. Go to OUT.
  - `WR_E`=1 and `en_any`=1: write key/data/LR into entry[`ADDR`] and set VALID. Go to IDLE.
  - `WR_E`=1 and `en_any`=0 (full): drop the packet, set OVF, go to IDLE.
  - `ADDR` ≥ N_ENTRY: treated as no-op. OVF is set if the command was a store.
- OUT: `OUT_REQ`=1 and all OUT_* are held stable until `OUT_ACK`. Then go to IDLE.
- Stored keys are unique, so at most one `FIRE` bit is set. If several are set, the controller's lowest-index choice is honoured.
- Controller outputs are ignored outside ACT, including the controller's post-reset value `DEL`=1.
- OVF clears only on reset.

## Timing
- Reset (synchronous, `MR`=0 at a `CP` edge):
  - State = IDLE.
  - All VALID = 0, FIRE = 0, MF = 0.
  - OUT_REQ = 0; OUT_PAIR, OUT_KEY, OUT_L, OUT_R = 0.
  - OVF = 0, en_any = 0.
  - `IN_ACK` = 1 from the first cycle after reset.
- Reset mid-operation discards the held packet and all entries.
- Latency: with input accepted at edge E0, MATCH follows E0 and ACT follows E1. Action and output register load happen at E2. `OUT_REQ` is high after E2.
- A stored entry is visible in VALID/FIRE from the cycle after E2.
- Throughput is at most one packet per 3 cycles without output stall. `IN_ACK` is low in MATCH, ACT and OUT.
- FIRE/VALID/MF are registered-stable for the whole MATCH cycle.

## Configuration
- `DDP_MM_OCC_EN` defined: adds output `OCC` [5:0], the occupied-entry count.
  - Increments on store and decrements on delete, in the same edge as the VALID change.
  - Resets to 0.
  - Never wraps, since the count is bounded by N_ENTRY.
- Undefined: no `OCC` port and no counter logic.

## Structure
- Package `ddp_mm_pkg`: N_ENTRY, ADDR_W = 6, the state enum (IDLE/MATCH/ACT/OUT), and the entry record typedef {valid, lr, key, data}.
- Sub-module `mm_entry`: a single entry holding the valid/lr/key/data registers, the write port, synchronous clear, and the key comparator producing its FIRE bit. It is instantiated N_ENTRY times.

## Test plan
- Store then match: send key 0x0012, LR=0, data 0x00AA, MF=1 → entry 0 valid, no output. Then send key 0x0012, LR=1, data 0x00BB → OUT_PAIR=1, OUT_L=0x00AA, OUT_R=0x00BB, VALID[0]=0.
- Bypass: send MF=1, key 0x0005, storing it in entry 0; then send MF=0, data 0x1234 → OUT_PAIR=0, OUT_L=0x1234, OUT_R=0, VALID unchanged.
- Full: fill 20 entries with distinct keys, then send a 21st distinct key → no output, OVF=1, VALID all-ones unchanged.
- Output stall: after a match, hold OUT_ACK=0 for 5 cycles → OUT_* stable and IN_ACK=0 throughout. OUT_ACK=1 → IDLE and IN_ACK=1 on the next cycle.
- Reset in ACT: assert MR=0 during ACT of a matching packet → no output, VALID all zero, OVF=0, OCC=0 if `DDP_MM_OCC_EN` is defined.
- Free-slot reuse: store keys A, B, C into entries 0-2, then match B → the next new key is stored in entry 1.
